spi_word_buffer: RTL

- Downstream stage of the SPI word receiver, in the 50 MHz system clock domain.
- Consumes the receiver's 16-bit word and its multi-cycle write strobe, and turns each strobe into exactly one captured word.
- Buffers captured words in a small synchronous FIFO and presents them on a valid/ready stream to the sample-processing logic.
- Counts words per frame and flags overflow.

---
 rtl/spi_buf_pkg.sv | 11 +
 rtl/spi_word_buffer_if.sv | 23 ++
 rtl/spi_fifo_core.sv | 55 +++++
 rtl/spi_word_buffer.sv | 116 +++++++++++
 4 files changed

// File: rtl/spi_buf_pkg.sv
// Shared constants and types for the SPI word buffer.
// Holds the default word width, FIFO depth and frame length, and the word type.
package spi_buf_pkg;

    localparam int WORD_W          = 16;
    localparam int DEF_DEPTH       = 8;
    localparam int DEF_FRAME_WORDS = 16384;

    typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/spi_word_buffer_if.sv
// Output word stream of the SPI word buffer.
// A word transfers on every clk edge where out_valid and out_ready are both
// high. out_valid never waits for out_ready, and out_data is stable while
// out_valid is high and out_ready is low.
interface spi_word_buffer_if #(
    parameter int WORD_W = spi_buf_pkg::WORD_W
);
    logic [WORD_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/spi_fifo_core.sv
// Synchronous FIFO storage for the SPI word buffer.
// Pointers carry one extra wrap bit so full and empty are told apart without
// a separate counter; the head entry is read combinationally.
module spi_fifo_core #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic                     push_ok,
    output logic [$clog2(DEPTH):0]   level
);
    import spi_buf_pkg::*;

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             pop_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok  = pop & ~empty;
    // A full FIFO still takes a word when the head leaves in the same cycle.
    assign push_ok = push & (~full | pop_ok);
    assign level   = wr_ptr - rd_ptr;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    // Pointer advance on accepted push and pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; cleared on reset so out_data reads zero afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end
endmodule

// File: rtl/spi_word_buffer.sv
// SPI word buffer: turns each rising edge of the receiver's level strobe into
// one captured word, queues it in a small FIFO, and streams it out on a
// valid/ready port. Counts accepted words per frame and flags dropped words.
// Optional build macro SPI_STROBE_SYNC_EN adds a 2-flop synchronizer on
// word_strobe ahead of edge detection.
module spi_word_buffer #(
    parameter int WORD_W      = spi_buf_pkg::WORD_W,
    parameter int DEPTH       = spi_buf_pkg::DEF_DEPTH,
    parameter int FRAME_WORDS = spi_buf_pkg::DEF_FRAME_WORDS
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WORD_W-1:0]      word_in,
    input  logic                   word_strobe,
    input  logic                   clr_ovf,
    spi_word_buffer_if.master      stream,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic                   frame_done
);
    import spi_buf_pkg::*;

    localparam int CW = $clog2(FRAME_WORDS + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_WORDS - 1);

    logic              strobe;
    logic              strobe_q;
    logic              rise;
    logic              push_req;
    logic [WORD_W-1:0] cap_word;
    logic              push_ok;
    logic              full;
    logic              empty;
    logic              drop;
    logic              pop;
    logic [CW-1:0]     word_cnt;

`ifdef SPI_STROBE_SYNC_EN
    logic [1:0] sync_ff;

    // Two-flop synchronizer for a strobe from another clock domain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_ff <= 2'b00;
        else       sync_ff <= {sync_ff[0], word_strobe};
    end

    assign strobe = sync_ff[1];
`else
    assign strobe = word_strobe;
`endif

    assign rise = strobe & ~strobe_q;

    // Edge history and capture register: one push request per strobe rise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            strobe_q <= 1'b0;
            push_req <= 1'b0;
            cap_word <= '0;
        end else begin
            strobe_q <= strobe;
            push_req <= rise;
            if (rise) cap_word <= word_in;
        end
    end

    assign pop  = ~empty & stream.out_ready;
    assign drop = push_req & ~push_ok;

    spi_fifo_core #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push_req),
        .pop     (pop),
        .wdata   (cap_word),
        .rdata   (stream.out_data),
        .full    (full),
        .empty   (empty),
        .push_ok (push_ok),
        .level   (level)
    );

    assign stream.out_valid = ~empty;

    // Sticky overflow; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        overflow <= 1'b0;
        else if (drop)    overflow <= 1'b1;
        else if (clr_ovf) overflow <= 1'b0;
    end

    // Frame counter over accepted words; wraps to zero with a one-cycle pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_cnt   <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (push_ok) begin
                if (word_cnt == LAST_CNT) begin
                    word_cnt   <= '0;
                    frame_done <= 1'b1;
                end else begin
                    word_cnt <= word_cnt + 1'b1;
                end
            end
        end
    end

    // Full is covered by push_ok; kept visible for debug probes.
    logic unused_full;
    assign unused_full = full;
endmodule
